// File: rtl/pci_bus_arbiter_if.sv
// PCI arbitration bundle: per-master REQ#/GNT#, shared FRAME#/IRDY# and owner status.
// The arbiter uses the master modport; initiators and the bus model use the slave modport.
interface pci_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int IDX_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] req_n;
  logic                   frame;
  logic                   irdy;
  logic [NUM_MASTERS-1:0] gnt_n;
  logic [IDX_W-1:0]       owner;
  logic                   owner_valid;
  logic                   timeout;

  modport master (
    input  req_n, frame, irdy,
    output gnt_n, owner, owner_valid, timeout
  );

  modport slave (
    output req_n, frame, irdy,
    input  gnt_n, owner, owner_valid, timeout
  );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter. It grants one clock after it samples a request on an idle bus.
// Grants change only while the bus is idle. An unused grant is revoked after TIMEOUT clocks.
module pci_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst,
  pci_bus_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, TURN} state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_nxt;
  logic [IDX_W-1:0]       owner_q, owner_nxt;
  logic [IDX_W-1:0]       rr_last, rr_last_nxt;
  logic                   owner_valid_q, owner_valid_nxt;
  logic                   timeout_q, timeout_nxt;
  logic [TMR_W-1:0]       timer, timer_nxt;
  logic [IDX_W-1:0]       win, cand;
  logic                   any_req;
  logic                   bus_idle;

  assign bus_idle = bus.frame & bus.irdy;

  // The search starts just past the last owner, so that master has the lowest priority next time.
  always_comb begin
    win     = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDX_W'((int'(rr_last) + k) % NUM_MASTERS);
      if (!any_req && !bus.req_n[cand]) begin
        win     = cand;
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      gnt_q         <= '1;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      timer         <= '0;
      rr_last       <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state         <= state_nxt;
      gnt_q         <= gnt_nxt;
      owner_q       <= owner_nxt;
      owner_valid_q <= owner_valid_nxt;
      timeout_q     <= timeout_nxt;
      timer         <= timer_nxt;
      rr_last       <= rr_last_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    gnt_nxt         = gnt_q;
    owner_nxt       = owner_q;
    owner_valid_nxt = owner_valid_q;
    timeout_nxt     = 1'b0;
    timer_nxt       = timer;
    rr_last_nxt     = rr_last;
    case (state)
      IDLE: begin
        gnt_nxt         = '1;
        owner_valid_nxt = 1'b0;
        if (any_req && bus_idle) begin
          state_nxt       = GRANT;
          gnt_nxt[win]    = 1'b0;
          owner_nxt       = win;
          owner_valid_nxt = 1'b1;
          timer_nxt       = '0;
        end
      end
      GRANT: begin
        // A withdrawn request does not consume the master's round-robin turn.
        if (!bus.frame) begin
          state_nxt   = BUSY;
          gnt_nxt     = '1;
          rr_last_nxt = owner_q;
        end else if (bus.req_n[owner_q]) begin
          state_nxt       = TURN;
          gnt_nxt         = '1;
          owner_valid_nxt = 1'b0;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          state_nxt       = TURN;
          gnt_nxt         = '1;
          owner_valid_nxt = 1'b0;
          rr_last_nxt     = owner_q;
          timeout_nxt     = 1'b1;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      BUSY: begin
        if (bus_idle) begin
          state_nxt       = TURN;
          owner_valid_nxt = 1'b0;
        end
      end
      TURN: begin
        state_nxt       = IDLE;
        gnt_nxt         = '1;
        owner_valid_nxt = 1'b0;
      end
      default: begin
        state_nxt       = IDLE;
        gnt_nxt         = '1;
        owner_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.gnt_n       = gnt_q;
  assign bus.owner       = owner_q;
  assign bus.owner_valid = owner_valid_q;
  assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Testbench for pci_bus_arbiter. A queue holds the expected grant sequence.
module tb_pci_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  pci_bus_arbiter_if #(.NUM_MASTERS(4)) bus ();

  pci_bus_arbiter #(.NUM_MASTERS(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [3:0] gnt_for(input int i);
    logic [3:0] m;
    m = 4'b0001 << i;
    return ~m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int max_cyc, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < max_cyc) begin
      step();
      cyc++;
      if (bus.gnt_n !== 4'b1111) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_n = 4'b1111;
    bus.frame = 1'b1;
    bus.irdy  = 1'b1;
    repeat (2) step();
    n_total++;
    if (bus.gnt_n !== 4'b1111) $display("FAIL reset_gnt: got %b want 1111", bus.gnt_n); else n_pass++;
    n_total++;
    if (bus.owner !== 2'd0) $display("FAIL reset_owner: got %0d want 0", bus.owner); else n_pass++;
    n_total++;
    if (bus.owner_valid !== 1'b0) $display("FAIL reset_owner_valid: got %b want 0", bus.owner_valid); else n_pass++;
    n_total++;
    if (bus.timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", bus.timeout); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int cyc; bit ok; int e;
    bus.req_n = 4'b1101;
    exp_q.push_back(1);
    wait_grant(10, cyc, ok);
    e = exp_q.pop_front();
    n_total++;
    if (!ok || cyc !== 1 || bus.owner !== e || bus.gnt_n !== gnt_for(e) || bus.owner_valid !== 1'b1)
      $display("FAIL single_grant: got gnt=%b owner=%0d vld=%b cyc=%0d want gnt=%b owner=%0d vld=1 cyc=1",
               bus.gnt_n, bus.owner, bus.owner_valid, cyc, gnt_for(e), e);
    else n_pass++;
    bus.frame = 1'b0;
    bus.irdy  = 1'b0;
    step();
    n_total++;
    if (bus.gnt_n !== 4'b1111 || bus.owner_valid !== 1'b1 || bus.owner !== 2'd1)
      $display("FAIL single_busy: got gnt=%b vld=%b owner=%0d want gnt=1111 vld=1 owner=1",
               bus.gnt_n, bus.owner_valid, bus.owner);
    else n_pass++;
    bus.req_n = 4'b1111;
    bus.frame = 1'b1;
    bus.irdy  = 1'b1;
    step();
    n_total++;
    if (bus.owner_valid !== 1'b0) $display("FAIL single_turn_vld: got %b want 0", bus.owner_valid); else n_pass++;
    step();
  endtask

  task automatic test_reset_async();
    int cyc; bit ok; int e;
    bus.req_n = 4'b1011;
    exp_q.push_back(2);
    wait_grant(10, cyc, ok);
    e = exp_q.pop_front();
    n_total++;
    if (!ok || bus.owner !== e || bus.gnt_n !== gnt_for(e))
      $display("FAIL arst_pre_grant: got gnt=%b owner=%0d want gnt=%b owner=%0d", bus.gnt_n, bus.owner, gnt_for(e), e);
    else n_pass++;
    bus.frame = 1'b0;
    bus.irdy  = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (bus.gnt_n !== 4'b1111 || bus.owner_valid !== 1'b0 || bus.owner !== 2'd0)
      $display("FAIL arst_busy: got gnt=%b vld=%b owner=%0d want gnt=1111 vld=0 owner=0",
               bus.gnt_n, bus.owner_valid, bus.owner);
    else n_pass++;
    step();
    rst = 1'b0;
    bus.frame = 1'b1;
    bus.irdy  = 1'b1;
    bus.req_n = 4'b1110;
    exp_q.push_back(0);
    wait_grant(10, cyc, ok);
    e = exp_q.pop_front();
    n_total++;
    if (!ok || bus.gnt_n !== gnt_for(e))
      $display("FAIL arst_regrant: got gnt=%b want %b", bus.gnt_n, gnt_for(e));
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (bus.gnt_n !== 4'b1111 || bus.owner_valid !== 1'b0)
      $display("FAIL arst_grant: got gnt=%b vld=%b want gnt=1111 vld=0", bus.gnt_n, bus.owner_valid);
    else n_pass++;
    step();
    rst = 1'b0;
    bus.req_n = 4'b1111;
  endtask

  task automatic test_round_robin();
    int cyc; bit ok; int e;
    bus.req_n = 4'b0000;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int i = 0; i < 5; i++) begin
      wait_grant(10, cyc, ok);
      e = exp_q.pop_front();
      n_total++;
      if (!ok || bus.owner !== e || bus.gnt_n !== gnt_for(e) || cyc !== (i == 0 ? 1 : 3))
        $display("FAIL rr_grant%0d: got gnt=%b owner=%0d cyc=%0d want gnt=%b owner=%0d cyc=%0d",
                 i, bus.gnt_n, bus.owner, cyc, gnt_for(e), e, (i == 0 ? 1 : 3));
      else n_pass++;
      bus.frame = 1'b0;
      bus.irdy  = 1'b0;
      step();
      n_total++;
      if (bus.gnt_n !== 4'b1111) $display("FAIL rr_busy%0d: got %b want 1111", i, bus.gnt_n); else n_pass++;
      bus.frame = 1'b1;
      bus.irdy  = 1'b1;
    end
    bus.req_n = 4'b1111;
    step();
    step();
  endtask

  task automatic test_timeout();
    int cyc; bit ok; int e; int low;
    bus.req_n = 4'b0011;
    exp_q.push_back(2);
    wait_grant(10, cyc, ok);
    e = exp_q.pop_front();
    n_total++;
    if (!ok || bus.gnt_n !== gnt_for(e))
      $display("FAIL to_grant: got gnt=%b want %b", bus.gnt_n, gnt_for(e));
    else n_pass++;
    low = ok ? 1 : 0;
    while (ok && bus.gnt_n[2] === 1'b0 && low < 40) begin
      step();
      if (bus.gnt_n[2] === 1'b0) low++;
    end
    n_total++;
    if (low !== 16) $display("FAIL to_len: got %0d clocks want 16", low); else n_pass++;
    n_total++;
    if (bus.timeout !== 1'b1 || bus.gnt_n !== 4'b1111 || bus.owner_valid !== 1'b0)
      $display("FAIL to_pulse: got timeout=%b gnt=%b vld=%b want 1 1111 0", bus.timeout, bus.gnt_n, bus.owner_valid);
    else n_pass++;
    step();
    n_total++;
    if (bus.timeout !== 1'b0) $display("FAIL to_pulse_end: got %b want 0", bus.timeout); else n_pass++;
    exp_q.push_back(3);
    wait_grant(10, cyc, ok);
    e = exp_q.pop_front();
    n_total++;
    if (!ok || cyc !== 1 || bus.owner !== e || bus.gnt_n !== gnt_for(e))
      $display("FAIL to_next: got gnt=%b owner=%0d cyc=%0d want gnt=%b owner=%0d cyc=1",
               bus.gnt_n, bus.owner, cyc, gnt_for(e), e);
    else n_pass++;
    bus.frame = 1'b0;
    bus.irdy  = 1'b0;
    step();
    bus.frame = 1'b1;
    bus.irdy  = 1'b1;
    bus.req_n = 4'b1111;
    step();
    step();
  endtask

  task automatic test_withdrawal();
    int cyc; bit ok; int e;
    bus.req_n = 4'b1101;
    exp_q.push_back(1);
    wait_grant(10, cyc, ok);
    e = exp_q.pop_front();
    n_total++;
    if (!ok || bus.owner !== e || bus.gnt_n !== gnt_for(e))
      $display("FAIL wd_grant: got gnt=%b owner=%0d want gnt=%b owner=%0d", bus.gnt_n, bus.owner, gnt_for(e), e);
    else n_pass++;
    bus.req_n = 4'b1111;
    step();
    n_total++;
    if (bus.gnt_n !== 4'b1111 || bus.timeout !== 1'b0 || bus.owner_valid !== 1'b0)
      $display("FAIL wd_revoke: got gnt=%b timeout=%b vld=%b want 1111 0 0", bus.gnt_n, bus.timeout, bus.owner_valid);
    else n_pass++;
    step();
    bus.req_n = 4'b0000;
    exp_q.push_back(0);
    wait_grant(10, cyc, ok);
    e = exp_q.pop_front();
    n_total++;
    if (!ok || bus.owner !== e || bus.gnt_n !== gnt_for(e))
      $display("FAIL wd_rr_kept: got gnt=%b owner=%0d want gnt=%b owner=%0d", bus.gnt_n, bus.owner, gnt_for(e), e);
    else n_pass++;
  endtask

  task automatic test_busy_hold();
    int cyc; bit ok; int e; bit bad;
    bus.frame = 1'b0;
    bus.irdy  = 1'b0;
    bus.req_n = 4'b0111;
    step();
    bad = 1'b0;
    repeat (10) begin
      step();
      if (bus.gnt_n !== 4'b1111 || bus.owner_valid !== 1'b1 || bus.owner !== 2'd0) bad = 1'b1;
    end
    n_total++;
    if (bad !== 1'b0) $display("FAIL busy_hold: got gnt=%b vld=%b owner=%0d want 1111 1 0", bus.gnt_n, bus.owner_valid, bus.owner);
    else n_pass++;
    bus.frame = 1'b1;
    bus.irdy  = 1'b1;
    exp_q.push_back(3);
    wait_grant(10, cyc, ok);
    e = exp_q.pop_front();
    n_total++;
    if (!ok || cyc !== 3 || bus.gnt_n !== gnt_for(e) || bus.owner !== e)
      $display("FAIL busy_release: got gnt=%b owner=%0d cyc=%0d want gnt=%b owner=%0d cyc=3",
               bus.gnt_n, bus.owner, cyc, gnt_for(e), e);
    else n_pass++;
    bus.req_n = 4'b1111;
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_async();
    test_round_robin();
    test_timeout();
    test_withdrawal();
    test_busy_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
